// File: rtl/sbus_dmem.sv
// sbus_dmem -- data-memory access unit between the execute stage and a simple
// request/acknowledge system bus.
//
// A load or store presented on mem_re/mem_we is checked for legality, then
// issued as one bus cycle. The pipeline is held through stall_o until the
// slave acknowledges or the wait budget runs out.
//
// Ports
//   clk          in   clock, all state updates on the rising edge
//   rst          in   asynchronous active-low reset
//   mem_re       in   load request
//   mem_we       in   store request
//   un_sign      in   1: zero-extend load result, 0: sign-extend
//   byte_mask    in   access size (0001 byte, 0011 half, 1111 word)
//   addr         in   byte address
//   wdata        in   right-justified store data
//   rdata_o      out  extended load result (registered)
//   stall_o      out  pipeline hold (combinational)
//   err_o        out  one-cycle access-fault pulse
//   bus_req_o    out  bus request, high for the whole bus cycle
//   bus_we_o     out  bus write
//   bus_addr_o   out  word-aligned bus address
//   bus_be_o     out  byte-lane enables
//   bus_wdata_o  out  lane-aligned store data
//   bus_ack_i    in   slave completion
//   bus_rdata_i  in   slave read data, valid with bus_ack_i
module sbus_dmem #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic        un_sign,
  input  logic [3:0]  byte_mask,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  off_q, off_d;
  logic [3:0]  mask_q, mask_d;
  logic        uns_q, uns_d;
  logic        we_q, we_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;

  logic any_req;
  logic mask_ok;
  logic align_ok;
  logic legal;
  logic timeout_hit;

  // Select the addressed lane(s) of the bus word and extend to 32 bits.
  function automatic logic [31:0] load_ext(input logic [31:0] word,
                                           input logic [1:0]  off,
                                           input logic [3:0]  mask,
                                           input logic        uns);
    logic [31:0] s;
    s = word >> {off, 3'b000};
    case (mask)
      4'b0001: load_ext = {{24{~uns & s[7]}}, s[7:0]};
      4'b0011: load_ext = {{16{~uns & s[15]}}, s[15:0]};
      default: load_ext = s;
    endcase
  endfunction

  // Both strobes high is a request too: it must be answered with a fault
  // rather than silently dropped.
  assign any_req = mem_re | mem_we;
  assign mask_ok = (byte_mask == 4'b0001) || (byte_mask == 4'b0011) ||
                   (byte_mask == 4'b1111);
  always_comb begin
    align_ok = 1'b1;
    if (byte_mask == 4'b0011) align_ok = ~addr[0];
    else if (byte_mask == 4'b1111) align_ok = (addr[1:0] == 2'b00);
  end
  assign legal       = (mem_re ^ mem_we) & mask_ok & align_ok;
  assign timeout_hit = (cnt_q == CNT_LAST);

  // State register and all other flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      off_q       <= '0;
      mask_q      <= '0;
      uns_q       <= 1'b0;
      we_q        <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      mask_q      <= mask_d;
      uns_q       <= uns_d;
      we_q        <= we_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  // Next-state logic. Ack is tested before the timeout so it wins a tie.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = legal ? BUSY : DONE;
      BUSY:    if (bus_ack_i || timeout_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered-output and datapath next values. Bus signals are loaded on
  // BUSY entry, held through BUSY and return to zero on leaving it.
  always_comb begin
    cnt_d       = cnt_q;
    off_d       = off_q;
    mask_d      = mask_q;
    uns_d       = uns_q;
    we_d        = we_q;
    rdata_d     = rdata_q;
    err_d       = 1'b0;
    bus_req_d   = 1'b0;
    bus_we_d    = 1'b0;
    bus_addr_d  = '0;
    bus_be_d    = '0;
    bus_wdata_d = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          if (legal) begin
            cnt_d       = '0;
            off_d       = addr[1:0];
            mask_d      = byte_mask;
            uns_d       = un_sign;
            we_d        = mem_we;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_we;
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_be_d    = byte_mask << addr[1:0];
            bus_wdata_d = mem_we ? (wdata << {addr[1:0], 3'b000}) : 32'h0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (bus_ack_i) begin
          if (!we_q) rdata_d = load_ext(bus_rdata_i, off_q, mask_q, uns_q);
        end else if (timeout_hit) begin
          err_d = 1'b1;
          if (!we_q) rdata_d = '0;
        end else begin
          cnt_d       = cnt_q + 8'd1;
          bus_req_d   = 1'b1;
          bus_we_d    = bus_we_q;
          bus_addr_d  = bus_addr_q;
          bus_be_d    = bus_be_q;
          bus_wdata_d = bus_wdata_q;
        end
      end
      default: ;
    endcase
  end

  // Output logic.
  assign stall_o     = (state_q == BUSY) || ((state_q == IDLE) && any_req);
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_be_o    = bus_be_q;
  assign bus_wdata_o = bus_wdata_q;

endmodule

// File: tb/tb_sbus_dmem.sv
// Directed testbench for sbus_dmem. Inputs are driven 1 ns after the rising
// edge and outputs are sampled there as well, so each step() moves one cycle.
module tb_sbus_dmem;
  localparam int TO = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_re = 1'b0, mem_we = 1'b0, un_sign = 1'b0;
  logic [3:0]  byte_mask = 4'b0000;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata_o;
  logic        stall_o, err_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;

  int checks = 0;
  int failures = 0;

  sbus_dmem #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_re(mem_re), .mem_we(mem_we), .un_sign(un_sign),
    .byte_mask(byte_mask), .addr(addr), .wdata(wdata),
    .rdata_o(rdata_o), .stall_o(stall_o), .err_o(err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic no_req();
    mem_re = 1'b0; mem_we = 1'b0; un_sign = 1'b0;
    byte_mask = 4'b0000; addr = '0; wdata = '0;
  endtask

  task automatic drive(input logic re, input logic we, input logic uns,
                       input logic [3:0] m, input logic [31:0] a,
                       input logic [31:0] d);
    mem_re = re; mem_we = we; un_sign = uns;
    byte_mask = m; addr = a; wdata = d;
  endtask

  task automatic test_reset();
    step(); step();
    checks++; if (rdata_o !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=%h", rdata_o, 32'h0); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err_o); end
    checks++; if (bus_req_o !== 1'b0 || bus_we_o !== 1'b0) begin failures++; $display("FAIL rst_req_we got=%b%b exp=00", bus_req_o, bus_we_o); end
    checks++; if (bus_addr_o !== 32'h0 || bus_be_o !== 4'h0 || bus_wdata_o !== 32'h0) begin failures++; $display("FAIL rst_bus got=%h/%h/%h exp=0", bus_addr_o, bus_be_o, bus_wdata_o); end
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", stall_o); end
    // release mid-cycle with a request already waiting: first edge takes it
    #2;
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 4'b1111, 32'h10, 32'h0);
    step();
    checks++; if (bus_req_o !== 1'b1) begin failures++; $display("FAIL first_req got=%b exp=1", bus_req_o); end
    checks++; if (bus_addr_o !== 32'h10) begin failures++; $display("FAIL first_addr got=%h exp=%h", bus_addr_o, 32'h10); end
    bus_ack_i = 1'b1; bus_rdata_i = 32'h1122_3344;
    step();
    bus_ack_i = 1'b0;
    checks++; if (rdata_o !== 32'h1122_3344) begin failures++; $display("FAIL first_rdata got=%h exp=%h", rdata_o, 32'h11223344); end
    no_req();
    step();
  endtask

  task automatic test_load_byte();
    drive(1'b1, 1'b0, 1'b0, 4'b0001, 32'h103, 32'h0);
    #1;
    checks++; if (stall_o !== 1'b1 || bus_req_o !== 1'b0) begin failures++; $display("FAIL lb_cycleN stall/req got=%b%b exp=10", stall_o, bus_req_o); end
    step();
    checks++; if (bus_req_o !== 1'b1 || bus_we_o !== 1'b0) begin failures++; $display("FAIL lb_req_we got=%b%b exp=10", bus_req_o, bus_we_o); end
    checks++; if (bus_be_o !== 4'b1000) begin failures++; $display("FAIL lb_be got=%b exp=1000", bus_be_o); end
    checks++; if (bus_addr_o !== 32'h100) begin failures++; $display("FAIL lb_addr got=%h exp=%h", bus_addr_o, 32'h100); end
    checks++; if (bus_wdata_o !== 32'h0) begin failures++; $display("FAIL lb_wdata got=%h exp=0", bus_wdata_o); end
    bus_ack_i = 1'b1; bus_rdata_i = 32'h80FF_1234;
    step();
    bus_ack_i = 1'b0;
    checks++; if (rdata_o !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_rdata got=%h exp=%h", rdata_o, 32'hFFFFFF80); end
    checks++; if (stall_o !== 1'b0 || err_o !== 1'b0 || bus_req_o !== 1'b0) begin failures++; $display("FAIL lb_done stall/err/req got=%b%b%b exp=000", stall_o, err_o, bus_req_o); end
    no_req();
    step();
  endtask

  task automatic test_store_half();
    int stall_cycles;
    stall_cycles = 0;
    drive(1'b0, 1'b1, 1'b0, 4'b0011, 32'h22, 32'h0000_ABCD);
    step();
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus_req_o !== 1'b1 || bus_we_o !== 1'b1) begin failures++; $display("FAIL sh_req_we[%0d] got=%b%b exp=11", i, bus_req_o, bus_we_o); end
      checks++; if (bus_be_o !== 4'b1100 || bus_addr_o !== 32'h20) begin failures++; $display("FAIL sh_be_addr[%0d] got=%b/%h exp=1100/20", i, bus_be_o, bus_addr_o); end
      checks++; if (bus_wdata_o !== 32'hABCD_0000) begin failures++; $display("FAIL sh_wdata[%0d] got=%h exp=%h", i, bus_wdata_o, 32'hABCD0000); end
      if (stall_o) stall_cycles++;
      if (i == 3) begin bus_ack_i = 1'b1; bus_rdata_i = 32'h5555_5555; end
      step();
    end
    bus_ack_i = 1'b0;
    checks++; if (stall_cycles != 4) begin failures++; $display("FAIL sh_stall_cycles got=%0d exp=4", stall_cycles); end
    checks++; if (stall_o !== 1'b0 || err_o !== 1'b0 || bus_req_o !== 1'b0) begin failures++; $display("FAIL sh_done stall/err/req got=%b%b%b exp=000", stall_o, err_o, bus_req_o); end
    checks++; if (rdata_o !== 32'hFFFF_FF80) begin failures++; $display("FAIL sh_rdata_kept got=%h exp=%h", rdata_o, 32'hFFFFFF80); end
    no_req();
    step();
  endtask

  task automatic test_illegal();
    logic [3:0]  m [3];
    logic [31:0] a [3];
    logic        we [3];
    m[0] = 4'b1111; a[0] = 32'h41; we[0] = 1'b0;  // misaligned word
    m[1] = 4'b0111; a[1] = 32'h40; we[1] = 1'b0;  // bad size encoding
    m[2] = 4'b0001; a[2] = 32'h40; we[2] = 1'b1;  // re and we together
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, we[i], 1'b0, m[i], a[i], 32'h0);
      step();
      checks++; if (err_o !== 1'b1 || bus_req_o !== 1'b0 || stall_o !== 1'b0) begin failures++; $display("FAIL ill[%0d] err/req/stall got=%b%b%b exp=100", i, err_o, bus_req_o, stall_o); end
      no_req();
      step();
      checks++; if (err_o !== 1'b0 || bus_req_o !== 1'b0) begin failures++; $display("FAIL ill_after[%0d] err/req got=%b%b exp=00", i, err_o, bus_req_o); end
    end
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    drive(1'b1, 1'b0, 1'b1, 4'b1111, 32'h80, 32'h0);
    step();
    while (bus_req_o === 1'b1 && n < 40) begin n++; step(); end
    checks++; if (n != TO) begin failures++; $display("FAIL to_req_cycles got=%0d exp=%0d", n, TO); end
    checks++; if (err_o !== 1'b1 || rdata_o !== 32'h0) begin failures++; $display("FAIL to_done err/rdata got=%b/%h exp=1/0", err_o, rdata_o); end
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL to_stall got=%b exp=0", stall_o); end
    no_req();
    step();
    // acknowledge on the very last allowed cycle
    drive(1'b1, 1'b0, 1'b1, 4'b1111, 32'h84, 32'h0);
    step();
    for (int i = 0; i < TO; i++) begin
      if (i == TO - 1) begin
        checks++; if (bus_req_o !== 1'b1) begin failures++; $display("FAIL to_last_req got=%b exp=1", bus_req_o); end
        bus_ack_i = 1'b1; bus_rdata_i = 32'h1234_5678;
      end
      step();
    end
    bus_ack_i = 1'b0;
    checks++; if (err_o !== 1'b0 || rdata_o !== 32'h1234_5678) begin failures++; $display("FAIL to_ack_wins err/rdata got=%b/%h exp=0/12345678", err_o, rdata_o); end
    no_req();
    step();
  endtask

  task automatic test_reset_mid_busy();
    drive(1'b1, 1'b0, 1'b1, 4'b0001, 32'h1, 32'h0);
    step();
    checks++; if (bus_req_o !== 1'b1) begin failures++; $display("FAIL rmb_req got=%b exp=1", bus_req_o); end
    #2 rst = 1'b0;
    #1;
    checks++; if (bus_req_o !== 1'b0 || rdata_o !== 32'h0) begin failures++; $display("FAIL rmb_async req/rdata got=%b/%h exp=0/0", bus_req_o, rdata_o); end
    no_req();
    step();
    #2 rst = 1'b1;
    // late ack from the abandoned cycle
    bus_ack_i = 1'b1; bus_rdata_i = 32'hDEAD_BEEF;
    step();
    bus_ack_i = 1'b0;
    checks++; if (rdata_o !== 32'h0 || err_o !== 1'b0 || bus_req_o !== 1'b0) begin failures++; $display("FAIL rmb_ignored rdata/err/req got=%h/%b/%b exp=0/0/0", rdata_o, err_o, bus_req_o); end
    drive(1'b1, 1'b0, 1'b1, 4'b0001, 32'h1, 32'h0);
    step();
    bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_AB00;
    step();
    bus_ack_i = 1'b0;
    checks++; if (rdata_o !== 32'h0000_00AB || err_o !== 1'b0) begin failures++; $display("FAIL rmb_next rdata/err got=%h/%b exp=000000ab/0", rdata_o, err_o); end
    no_req();
    step();
  endtask

  task automatic test_back_to_back();
    int req_cycles;
    req_cycles = 0;
    drive(1'b1, 1'b0, 1'b1, 4'b0011, 32'h2, 32'h0);
    step();
    if (bus_req_o) req_cycles++;
    bus_ack_i = 1'b1; bus_rdata_i = 32'hFEDC_BA98;
    step();
    bus_ack_i = 1'b0;
    checks++; if (rdata_o !== 32'h0000_FEDC || stall_o !== 1'b0) begin failures++; $display("FAIL b2b_first rdata/stall got=%h/%b exp=0000fedc/0", rdata_o, stall_o); end
    if (bus_req_o) req_cycles++;
    step();
    drive(1'b1, 1'b0, 1'b1, 4'b0011, 32'h0, 32'h0);
    #1;
    checks++; if (bus_req_o !== 1'b0 || stall_o !== 1'b1) begin failures++; $display("FAIL b2b_idle req/stall got=%b%b exp=01", bus_req_o, stall_o); end
    step();
    if (bus_req_o) req_cycles++;
    checks++; if (bus_addr_o !== 32'h0 || bus_be_o !== 4'b0011) begin failures++; $display("FAIL b2b_second_bus addr/be got=%h/%b exp=0/0011", bus_addr_o, bus_be_o); end
    bus_ack_i = 1'b1;
    step();
    bus_ack_i = 1'b0;
    checks++; if (rdata_o !== 32'h0000_BA98 || stall_o !== 1'b0) begin failures++; $display("FAIL b2b_second rdata/stall got=%h/%b exp=0000ba98/0", rdata_o, stall_o); end
    if (bus_req_o) req_cycles++;
    no_req();
    step();
    if (bus_req_o) req_cycles++;
    checks++; if (req_cycles != 2) begin failures++; $display("FAIL b2b_bus_cycles got=%0d exp=2", req_cycles); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_byte();
    test_store_half();
    test_illegal();
    test_timeout();
    test_reset_mid_busy();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
